// File: rtl/hvtx_pkg.sv
// Shared types for the HDMI transmit pixel-stream front end.
package hvtx_pkg;

    typedef logic [2:0][7:0] pixel_t;

    typedef struct packed {
        logic   sof;
        logic   eol;
        pixel_t data;
    } stream_entry_t;

    typedef enum logic [1:0] {
        SEEK,
        ARMED,
        RUN
    } src_state_t;

endpackage

// File: rtl/hvtx_fifo.sv
// Single-clock first-word-fall-through FIFO; the head is readable whenever
// o_empty is low, and a word written this cycle shows up on the next one.
module hvtx_fifo
    import hvtx_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = stream_entry_t
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  entry_t                   i_push_data,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output entry_t                   o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_ok, pop_ok;
    entry_t        mem_q [DEPTH];

    assign o_full  = (level_q == (AW+1)'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign o_head  = mem_q[rd_ptr_q];

    // Guard against callers pushing into a full or popping an empty FIFO.
    assign push_ok = i_push & ~o_full;
    assign pop_ok  = i_pop & ~o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_push_data;
    end

endmodule

// File: rtl/hvtx_stream_src.sv
// Buffers a valid/ready RGB stream and pops it in step with the raster cursor,
// delivering video two cycles after the cursor to line up with hs/vs/de.
module hvtx_stream_src
    import hvtx_pkg::*;
#(
    parameter int          WID           = 12,
    parameter int          ACTIVE_WIDTH  = 1280,
    parameter int          ACTIVE_HEIGHT = 720,
    parameter int          DEPTH         = 16,
    parameter logic [23:0] FILL_COLOR    = 24'h000000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [WID-1:0]           i_x,
    input  logic [WID-1:0]           i_y,
    input  logic [2:0][7:0]          i_s_data,
    input  logic                     i_s_sof,
    input  logic                     i_s_eol,
    input  logic                     i_s_valid,
    output logic                     o_s_ready,
    output logic [2:0][7:0]          o_video,
    output logic                     o_locked,
    output logic                     o_underflow,
    output logic                     o_misalign,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam pixel_t FILL_PX = FILL_COLOR;

    src_state_t    state_q, state_d;
    logic          act_q, act_d, org_q, org_d, last_q, last_d;
    pixel_t        video_q, video_d;
    logic          underflow_q, underflow_d;
    logic          misalign_q, misalign_d;
    logic          full, empty, push, pop;
    stream_entry_t head, push_entry;

    assign o_s_ready  = ~full & ~i_rst;
    assign push       = i_s_valid & o_s_ready;
    assign push_entry = '{sof: i_s_sof, eol: i_s_eol, data: i_s_data};

    hvtx_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (stream_entry_t)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data (push_entry),
        .i_pop       (pop),
        .o_full      (full),
        .o_empty     (empty),
        .o_level     (o_level),
        .o_head      (head)
    );

    always_comb begin
        act_d  = (i_x < WID'(ACTIVE_WIDTH)) & (i_y < WID'(ACTIVE_HEIGHT));
        org_d  = (i_x == '0) & (i_y == '0);
        last_d = (i_x == WID'(ACTIVE_WIDTH - 1));
    end

    // Pop decision works off the stage-1 cursor flags; stage 2 is the output register.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        video_d     = FILL_PX;
        underflow_d = 1'b0;
        misalign_d  = 1'b0;
        case (state_q)
            SEEK: begin
                if (!empty) begin
                    if (head.sof) state_d = ARMED;
                    else          pop     = 1'b1;
                end
            end
            ARMED: begin
                if (!empty && org_q && act_q) begin
                    pop     = 1'b1;
                    video_d = head.data;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (act_q) begin
                    if (empty) begin
                        underflow_d = 1'b1;
                        state_d     = SEEK;
                    end else if (head.sof && !org_q) begin
                        misalign_d = 1'b1;
                        state_d    = ARMED;
                    end else begin
                        pop     = 1'b1;
                        video_d = head.data;
                        if (head.eol != last_q) begin
                            misalign_d = 1'b1;
                            state_d    = SEEK;
                        end
                    end
                end
            end
            default: state_d = SEEK;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= SEEK;
            act_q       <= 1'b0;
            org_q       <= 1'b0;
            last_q      <= 1'b0;
            video_q     <= FILL_PX;
            underflow_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            org_q       <= org_d;
            last_q      <= last_d;
            video_q     <= video_d;
            underflow_q <= underflow_d;
            misalign_q  <= misalign_d;
        end
    end

    assign o_video     = video_q;
    assign o_locked    = (state_q == RUN);
    assign o_underflow = underflow_q;
    assign o_misalign  = misalign_q;

endmodule

// File: tb/tb_hvtx_stream_src.sv
// Directed bench for hvtx_stream_src: 8x4 active area inside a 12x6 raster.
module tb_hvtx_stream_src;
    import hvtx_pkg::*;

    localparam int          WID  = 12;
    localparam int          AW_  = 8;
    localparam int          AH_  = 4;
    localparam int          FW   = 12;
    localparam int          FH   = 6;
    localparam logic [23:0] FILL = 24'hC3C3C3;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b0;
    logic [WID-1:0] i_x = '0, i_y = '0;
    pixel_t         i_s_data = '0;
    logic           i_s_sof = 1'b0, i_s_eol = 1'b0, i_s_valid = 1'b0;
    logic           o_s_ready;
    pixel_t         o_video;
    logic           o_locked, o_underflow, o_misalign;
    logic [4:0]     o_level;

    int          n_chk = 0, n_err = 0;
    logic [25:0] src_q[$];
    bit          src_en = 0, run_cur = 0;
    int          cx = 0, cy = 0, p1x = 0, p1y = 0, dx = 0, dy = 0, n_acc = 0, lin = 0;

    hvtx_stream_src #(
        .WID(WID), .ACTIVE_WIDTH(AW_), .ACTIVE_HEIGHT(AH_), .DEPTH(16), .FILL_COLOR(FILL)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_x(i_x), .i_y(i_y),
        .i_s_data(i_s_data), .i_s_sof(i_s_sof), .i_s_eol(i_s_eol), .i_s_valid(i_s_valid),
        .o_s_ready(o_s_ready), .o_video(o_video), .o_locked(o_locked),
        .o_underflow(o_underflow), .o_misalign(o_misalign), .o_level(o_level)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ob();
        return {5'b0, o_locked, o_underflow, o_misalign, o_video};
    endfunction

    function automatic logic [31:0] ex(input bit l, input bit u, input bit m, input logic [23:0] v);
        return {5'b0, l, u, m, v};
    endfunction

    function automatic logic [23:0] pix(input int x, input int y);
        logic [7:0] v;
        v = 8'(8 * y + x);
        return {v, v, v};
    endfunction

    function automatic bit is_act(input int x, input int y);
        return (x < AW_) && (y < AH_);
    endfunction

    // Frames of 32 words, data = index, sof on word 0, eol on every 8th;
    // 'bad' adds a stray eol to that word of the first frame only.
    task automatic add_frames(input int nf, input int bad);
        logic [7:0]  v;
        logic [25:0] w;
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < 32; i++) begin
                v = 8'(i);
                w = {(i == 0), ((i % 8 == 7) || (f == 0 && i == bad)), v, v, v};
                src_q.push_back(w);
            end
        end
    endtask

    // Called at a negedge; returns at the next negedge. (dx,dy) is the cursor
    // whose video is visible on the outputs afterwards.
    task automatic tick();
        bit acc;
        if (run_cur) begin i_x = WID'(cx); i_y = WID'(cy); end
        else         begin i_x = WID'(FW - 1); i_y = WID'(FH - 1); end
        if (src_en && src_q.size() > 0) begin
            i_s_valid = 1'b1;
            i_s_sof   = src_q[0][25];
            i_s_eol   = src_q[0][24];
            i_s_data  = src_q[0][23:0];
        end else begin
            i_s_valid = 1'b0;
            i_s_sof   = 1'b0;
            i_s_eol   = 1'b0;
            i_s_data  = '0;
        end
        #1;
        acc = i_s_valid && o_s_ready;
        @(posedge i_clk);
        if (acc) begin
            void'(src_q.pop_front());
            n_acc++;
        end
        dx  = p1x;
        dy  = p1y;
        p1x = int'(i_x);
        p1y = int'(i_y);
        if (run_cur) begin
            cx++;
            if (cx == FW) begin
                cx = 0;
                cy = (cy == FH - 1) ? 0 : cy + 1;
            end
        end
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        src_q.delete();
        src_en  = 0;
        run_cur = 0;
        tick();
        tick();
        chk("rst_out", ob(), ex(0, 0, 0, FILL));
        chk("rst_lvl", 32'(o_level), 32'd0);
        chk("rst_rdy", 32'(o_s_ready), 32'd0);
        i_rst = 1'b0;
        n_acc = 0;
    endtask

    task automatic start_cursor();
        cx = 0;
        cy = 0;
        run_cur = 1;
        tick();
        chk("prelock", ob(), ex(0, 0, 0, FILL));
    endtask

    task automatic run_pass(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            chk(tag, ob(), ex(1, 0, 0, is_act(dx, dy) ? pix(dx, dy) : FILL));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge i_clk);

        // lock and pass-through over three frames
        do_reset();
        add_frames(4, -1);
        src_en = 1;
        repeat (20) tick();
        chk("t1_lvl", 32'(o_level), 32'd16);
        chk("t1_idle", ob(), ex(0, 0, 0, FILL));
        start_cursor();
        run_pass(3 * FW * FH, "t1_pass");

        // garbage ahead of the first sof is dropped
        do_reset();
        for (int k = 0; k < 5; k++) src_q.push_back({2'b00, 24'(24'hE0E0E0 + k)});
        add_frames(3, -1);
        src_en = 1;
        repeat (6) tick();
        chk("t2_garb_lvl", 32'(o_level), 32'd1);
        repeat (24) tick();
        chk("t2_lvl", 32'(o_level), 32'd16);
        chk("t2_acc", 32'(n_acc), 32'd21);
        start_cursor();
        run_pass(FW * FH, "t2_pass");

        // underflow after 20 pixels, relock next frame
        do_reset();
        add_frames(1, -1);
        while (src_q.size() > 20) void'(src_q.pop_back());
        src_en = 1;
        repeat (20) tick();
        start_cursor();
        for (int j = 0; j < FW * FH; j++) begin
            tick();
            lin = dy * FW + dx;
            if (lin < 28)
                chk("t3_run", ob(), ex(1, 0, 0, is_act(dx, dy) ? pix(dx, dy) : FILL));
            else if (lin == 28)
                chk("t3_uflow", ob(), ex(0, 1, 0, FILL));
            else
                chk("t3_after", ob(), ex(0, 0, 0, FILL));
            if (lin == 28) add_frames(2, -1);
        end
        run_pass(FW * FH, "t3_relock");

        // stray eol at (5,1)
        do_reset();
        add_frames(3, 13);
        src_en = 1;
        repeat (20) tick();
        start_cursor();
        for (int j = 0; j < FW * FH; j++) begin
            tick();
            lin = dy * FW + dx;
            if (lin < 17)
                chk("t4_run", ob(), ex(1, 0, 0, is_act(dx, dy) ? pix(dx, dy) : FILL));
            else if (lin == 17)
                chk("t4_misalign", ob(), ex(0, 0, 1, pix(5, 1)));
            else
                chk("t4_after", ob(), ex(0, 0, 0, FILL));
        end
        run_pass(FW * FH, "t4_relock");

        // backpressure while armed
        do_reset();
        add_frames(3, -1);
        src_en = 1;
        repeat (24) tick();
        chk("t5_acc", 32'(n_acc), 32'd16);
        chk("t5_rdy", 32'(o_s_ready), 32'd0);
        chk("t5_lvl", 32'(o_level), 32'd16);
        start_cursor();
        chk("t5_rdy_hold", 32'(o_s_ready), 32'd0);
        tick();
        chk("t5_rdy_back", 32'(o_s_ready), 32'd1);
        chk("t5_lvl_pop", 32'(o_level), 32'd15);
        chk("t5_first", ob(), ex(1, 0, 0, pix(0, 0)));
        run_pass(3, "t5_pass");

        // asynchronous reset mid-line with no clock edge
        #1 i_rst = 1'b1;
        #1;
        chk("t6_vid", 32'(o_video), 32'(FILL));
        chk("t6_lock", 32'(o_locked), 32'd0);
        chk("t6_lvl", 32'(o_level), 32'd0);
        chk("t6_rdy_rst", 32'(o_s_ready), 32'd0);
        #1 i_rst = 1'b0;
        #1;
        chk("t6_rdy_rel", 32'(o_s_ready), 32'd1);
        @(negedge i_clk);
        chk("t6_post", ob(), ex(0, 0, 0, FILL));
        chk("t6_post_lvl", 32'(o_level), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
